// File: rtl/fetch_pkg.sv
// fetch_pkg: shared widths for the instruction fetch stage
package fetch_pkg;
  localparam int INSTR_W = 18;
endpackage

// File: rtl/fetch_queue.sv
// fetch_queue: synchronous FIFO with push/pop/flush, full/empty and occupancy count
module fetch_queue #(
  parameter int W = 8,
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic push,
  input  logic pop,
  input  logic flush,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] rdata,
  output logic full,
  output logic empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic do_push, do_pop;
  assign do_push = push && !flush;
  assign do_pop = pop && !empty && !flush;
  assign empty = count == '0;
  assign full = count == CW'(DEPTH);
  assign rdata = empty ? '0 : mem[rd_ptr];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(do_push);
      rd_ptr <= rd_ptr + AW'(do_pop);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  always_ff @(posedge clk)
    if (do_push) mem[wr_ptr] <= wdata;
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: fetch PC, req/ack instruction memory port and decode queue; FETCH_PERF_EN adds a bubble counter
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int PC_W = 16,
  parameter int QDEPTH = 2,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic clk,
  input  logic rst_n,
  output logic imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [INSTR_W-1:0] ir,
  output logic [PC_W-1:0] ir_pc,
  output logic ir_valid,
  input  logic ir_ready,
  input  logic redirect_valid,
  input  logic [PC_W-1:0] redirect_pc
`ifdef FETCH_PERF_EN
  ,
  input  logic perf_clr,
  output logic [15:0] perf_bubbles
`endif
);
  localparam int CW = $clog2(QDEPTH + 1);
  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [PC_W-1:0] pc;
  } fetch_entry_t;
  fetch_entry_t wentry, head;
  logic run, pend, drop, acc, push, pop, full, empty;
  logic [PC_W-1:0] fetch_pc, pend_addr;
  logic [CW-1:0] count;
  // a pending request is never withdrawn, so pend alone keeps req high
  assign imem_req = pend || (run && count < CW'(QDEPTH) && !redirect_valid);
  assign imem_addr = pend ? pend_addr : fetch_pc;
  assign acc = imem_req && imem_ack;
  assign push = acc && !drop && !redirect_valid;
  assign pop = ir_valid && ir_ready && !redirect_valid;
  assign ir_valid = !empty;
  assign wentry = {imem_rdata, imem_addr};
  assign ir = head.instr;
  assign ir_pc = head.pc;
  fetch_queue #(.W($bits(fetch_entry_t)), .DEPTH(QDEPTH)) u_queue (
    .clk(clk),
    .rst_n(rst_n),
    .push(push),
    .pop(pop),
    .flush(redirect_valid),
    .wdata(wentry),
    .rdata(head),
    .full(full),
    .empty(empty),
    .count(count)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      run <= 1'b0;
      pend <= 1'b0;
      drop <= 1'b0;
      pend_addr <= '0;
      fetch_pc <= RESET_PC;
    end else begin
      run <= 1'b1;
      pend <= imem_req && !imem_ack;
      pend_addr <= imem_addr;
      drop <= (redirect_valid && pend && !imem_ack) || (drop && !acc);
      fetch_pc <= redirect_valid ? redirect_pc : fetch_pc + PC_W'(push);
    end
  always_ff @(posedge clk)
    if (rst_n) assert (!(push && full && !pop));
`ifdef FETCH_PERF_EN
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) perf_bubbles <= '0;
    else if (perf_clr) perf_bubbles <= '0;
    else if (!ir_valid && !redirect_valid && perf_bubbles != 16'hFFFF) perf_bubbles <= perf_bubbles + 16'd1;
`endif
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: table vectors, hand sequences and a queue-based random reference for fetch_unit
module tb_fetch_unit;
  logic clk = 1'b0, rst_n = 1'b0, rst1_n = 1'b0;
  always #5 clk = ~clk;
  logic imem_req, imem_ack, ir_valid, ir_ready, redirect_valid;
  logic [15:0] imem_addr, ir_pc, redirect_pc;
  logic [17:0] imem_rdata, ir;
  logic req1, v1;
  logic [3:0] addr1, pc1;
  logic [17:0] ir1;
`ifdef FETCH_PERF_EN
  logic perf_clr, clr1;
  logic [15:0] perf_bubbles, bub1;
`endif
  int total = 0, bad = 0;

  fetch_unit u_dut (
    .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .ir(ir), .ir_pc(ir_pc),
    .ir_valid(ir_valid), .ir_ready(ir_ready), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc)
`ifdef FETCH_PERF_EN
    , .perf_clr(perf_clr), .perf_bubbles(perf_bubbles)
`endif
  );

  fetch_unit #(.PC_W(4), .QDEPTH(2), .RESET_PC(4'd14)) u_narrow (
    .clk(clk), .rst_n(rst1_n), .imem_req(req1), .imem_addr(addr1),
    .imem_ack(1'b1), .imem_rdata(18'h0), .ir(ir1), .ir_pc(pc1),
    .ir_valid(v1), .ir_ready(1'b1), .redirect_valid(1'b0), .redirect_pc(4'h0)
`ifdef FETCH_PERF_EN
    , .perf_clr(clr1), .perf_bubbles(bub1)
`endif
  );

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // called at a negedge; leaves rst_n released at a negedge
  task automatic do_reset();
    rst_n = 1'b0;
    imem_ack = 1'b0; ir_ready = 1'b0; redirect_valid = 1'b0;
    redirect_pc = '0; imem_rdata = '0;
`ifdef FETCH_PERF_EN
    perf_clr = 1'b0;
`endif
    #1;
    chk("rst req", 32'(imem_req), 0);
    chk("rst valid", 32'(ir_valid), 0);
    chk("rst ir", 32'(ir), 0);
    chk("rst ir_pc", 32'(ir_pc), 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  typedef struct {
    bit rst, ack, rdy, rv;
    logic [15:0] rpc;
    logic [17:0] rd;
    bit e_req;
    logic [15:0] e_addr;
    bit e_v;
    logic [15:0] e_pc;
    logic [17:0] e_ir;
  } vec_t;
  vec_t vecs[$];

  function automatic void add(bit rst, bit ack, bit rdy, bit rv, logic [15:0] rpc, logic [17:0] rd,
                              bit e_req, logic [15:0] e_addr, bit e_v, logic [15:0] e_pc, logic [17:0] e_ir);
    vecs.push_back('{rst, ack, rdy, rv, rpc, rd, e_req, e_addr, e_v, e_pc, e_ir});
  endfunction

  typedef struct {
    logic [17:0] ins;
    logic [15:0] pc;
  } ent_t;
  ent_t q[$];
  bit m_pend, m_drop, m_run, m_req, m_acc;
  logic [15:0] m_pc, m_paddr, m_addr;

  initial begin
    // narrow instance: RESET_PC=14 wraps modulo 16
    imem_ack = 1'b0; ir_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; imem_rdata = '0;
`ifdef FETCH_PERF_EN
    perf_clr = 1'b0; clr1 = 1'b0;
`endif
    @(negedge clk);
    rst1_n = 1'b1;
    #1 chk("w4 req0", 32'(req1), 0);
    @(negedge clk); #1 chk("w4 addr14", 32'(addr1), 14);
    @(negedge clk); #1 chk("w4 addr15", 32'(addr1), 15);
    chk("w4 v", 32'(v1), 1);
    chk("w4 pc14", 32'(pc1), 14);
    @(negedge clk); #1 chk("w4 addr0", 32'(addr1), 0);
    chk("w4 pc15", 32'(pc1), 15);
    @(negedge clk); #1 chk("w4 addr1", 32'(addr1), 1);
    chk("w4 pc0", 32'(pc1), 0);

    // rst ack rdy rv rpc rd | req addr v pc ir
    add(1, 1, 1, 0, 0, 18'h00,     0, 0, 0, 0, 0);
    add(0, 1, 1, 0, 0, 18'h11,     1, 0, 0, 0, 0);
    add(0, 1, 1, 0, 0, 18'h12,     1, 1, 1, 0, 18'h11);
    add(0, 1, 1, 0, 0, 18'h13,     1, 2, 1, 1, 18'h12);
    add(0, 1, 1, 0, 0, 18'h14,     1, 3, 1, 2, 18'h13);
    // stalled consumer: two words then gating, one pop frees one slot
    add(1, 1, 0, 0, 0, 18'h00,     0, 0, 0, 0, 0);
    add(0, 1, 0, 0, 0, 18'h21,     1, 0, 0, 0, 0);
    add(0, 1, 0, 0, 0, 18'h22,     1, 1, 1, 0, 18'h21);
    add(0, 1, 0, 0, 0, 18'h23,     0, 0, 1, 0, 18'h21);
    add(0, 1, 1, 0, 0, 18'h24,     0, 0, 1, 0, 18'h21);
    add(0, 1, 0, 0, 0, 18'h25,     1, 2, 1, 1, 18'h22);
    add(0, 1, 0, 0, 0, 18'h26,     0, 0, 1, 1, 18'h22);
    // redirect while a request waits: address held, data dropped
    add(1, 0, 1, 0, 0, 18'h00,     0, 0, 0, 0, 0);
    add(0, 0, 1, 0, 0, 18'h00,     1, 0, 0, 0, 0);
    add(0, 0, 1, 1, 16'h0100, 0,   1, 0, 0, 0, 0);
    add(0, 0, 1, 0, 0, 18'h00,     1, 0, 0, 0, 0);
    add(0, 1, 1, 0, 0, 18'h3FFFF,  1, 0, 0, 0, 0);
    add(0, 0, 1, 0, 0, 18'h00,     1, 16'h0100, 0, 0, 0);
    add(0, 1, 1, 0, 0, 18'h31,     1, 16'h0100, 0, 0, 0);
    add(0, 0, 1, 0, 0, 18'h00,     1, 16'h0101, 1, 16'h0100, 18'h31);
    // second redirect while drop pending
    add(1, 0, 1, 0, 0, 18'h00,     0, 0, 0, 0, 0);
    add(0, 0, 1, 0, 0, 18'h00,     1, 0, 0, 0, 0);
    add(0, 0, 1, 1, 16'h0100, 0,   1, 0, 0, 0, 0);
    add(0, 0, 1, 1, 16'h0180, 0,   1, 0, 0, 0, 0);
    add(0, 1, 1, 0, 0, 18'h2AAAA,  1, 0, 0, 0, 0);
    add(0, 1, 1, 0, 0, 18'h41,     1, 16'h0180, 0, 0, 0);
    add(0, 0, 1, 0, 0, 18'h00,     1, 16'h0181, 1, 16'h0180, 18'h41);
    // redirect with full queue, ack and pop in the same cycle
    add(1, 1, 0, 0, 0, 18'h00,     0, 0, 0, 0, 0);
    add(0, 1, 0, 0, 0, 18'h51,     1, 0, 0, 0, 0);
    add(0, 1, 0, 0, 0, 18'h52,     1, 1, 1, 0, 18'h51);
    add(0, 1, 1, 1, 16'h0200, 18'h53, 0, 0, 1, 0, 18'h51);
    add(0, 0, 1, 0, 0, 18'h00,     1, 16'h0200, 0, 0, 0);
    add(0, 1, 1, 0, 0, 18'h54,     1, 16'h0200, 0, 0, 0);
    add(0, 0, 1, 0, 0, 18'h00,     1, 16'h0201, 1, 16'h0200, 18'h54);
    // 16-bit wrap
    add(1, 1, 1, 0, 0, 18'h00,     0, 0, 0, 0, 0);
    add(0, 1, 1, 1, 16'hFFFF, 18'h61, 0, 0, 0, 0, 0);
    add(0, 1, 1, 0, 0, 18'h62,     1, 16'hFFFF, 0, 0, 0);
    add(0, 1, 1, 0, 0, 18'h63,     1, 16'h0000, 1, 16'hFFFF, 18'h62);
    add(0, 1, 1, 0, 0, 18'h64,     1, 16'h0001, 1, 16'h0000, 18'h63);

    @(negedge clk);
    foreach (vecs[i]) begin
      if (vecs[i].rst) do_reset();
      imem_ack = vecs[i].ack; ir_ready = vecs[i].rdy; redirect_valid = vecs[i].rv;
      redirect_pc = vecs[i].rpc; imem_rdata = vecs[i].rd;
      #1;
      chk($sformatf("row%0d req", i), 32'(imem_req), 32'(vecs[i].e_req));
      if (vecs[i].e_req) chk($sformatf("row%0d addr", i), 32'(imem_addr), 32'(vecs[i].e_addr));
      chk($sformatf("row%0d valid", i), 32'(ir_valid), 32'(vecs[i].e_v));
      if (vecs[i].e_v) begin
        chk($sformatf("row%0d ir_pc", i), 32'(ir_pc), 32'(vecs[i].e_pc));
        chk($sformatf("row%0d ir", i), 32'(ir), 32'(vecs[i].e_ir));
      end
      @(negedge clk);
    end

`ifdef FETCH_PERF_EN
    do_reset();
    ir_ready = 1'b1;
    perf_clr = 1'b1;
    @(negedge clk);
    perf_clr = 1'b0;
    #1 chk("perf clr0", 32'(perf_bubbles), 0);
    repeat (5) @(negedge clk);
    #1 chk("perf five", 32'(perf_bubbles), 5);
    redirect_valid = 1'b1;
    @(negedge clk);
    redirect_valid = 1'b0;
    #1 chk("perf redirect", 32'(perf_bubbles), 5);
    perf_clr = 1'b1;
    @(negedge clk);
    perf_clr = 1'b0;
    #1 chk("perf clr", 32'(perf_bubbles), 0);
    @(negedge clk);
`endif

    // random traffic against a transaction-level reference
    do_reset();
    q.delete();
    m_pend = 0; m_drop = 0; m_run = 0; m_pc = 0; m_paddr = 0;
    for (int c = 0; c < 3000; c++) begin
      imem_ack = $urandom_range(0, 99) < 60;
      ir_ready = $urandom_range(0, 99) < 70;
      redirect_valid = $urandom_range(0, 99) < 8;
      redirect_pc = ($urandom_range(0, 3) == 0) ? 16'hFFFE : 16'($urandom);
      imem_rdata = 18'($urandom);
      #1;
      m_req = m_pend || (m_run && (q.size() + int'(m_pend)) < 2 && !redirect_valid);
      m_addr = m_pend ? m_paddr : m_pc;
      chk("rand req", 32'(imem_req), 32'(m_req));
      if (m_req) chk("rand addr", 32'(imem_addr), 32'(m_addr));
      chk("rand valid", 32'(ir_valid), 32'(q.size() > 0));
      if (q.size() > 0) begin
        chk("rand ir_pc", 32'(ir_pc), 32'(q[0].pc));
        chk("rand ir", 32'(ir), 32'(q[0].ins));
      end
      m_acc = m_req && imem_ack;
      if (redirect_valid) begin
        q.delete();
        if (m_req && !imem_ack) m_drop = 1;
        else if (m_acc) m_drop = 0;
        m_pc = redirect_pc;
      end else begin
        if (q.size() > 0 && ir_ready) void'(q.pop_front());
        if (m_acc && m_drop) m_drop = 0;
        else if (m_acc) begin
          q.push_back('{imem_rdata, m_addr});
          m_pc = 16'((32'(m_pc) + 1) % 65536);
        end
      end
      m_pend = m_req && !imem_ack;
      m_paddr = m_addr;
      m_run = 1;
      @(negedge clk);
    end
    #2 do_reset();
    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage directly upstream of the decoder.
- Maintains the fetch PC and issues word reads to instruction memory over a req/ack handshake.
- Buffers returned 18-bit instruction words in a small queue and presents them, with their PCs, to decode/execute via valid/ready.
- Accepts redirects (taken jumps, calls, register-indirect jumps) from execute and discards all stale fetches.

Parameters:
PC_W, 16, fetch address width in instruction words; PC wraps modulo 2^PC_W
QDEPTH, 2, instruction queue entries; power of two, 2..8
RESET_PC, 0, fetch PC loaded at reset

Ports:
clk  in  1  clock; all state changes on rising edge
rst_n  in  1  asynchronous active-low reset
imem_req  out  1  read request to instruction memory
imem_addr  out  PC_W  word address of the request
imem_ack  in  1  request accepted; read data valid in the same cycle
imem_rdata  in  18  instruction word, valid when imem_ack=1
ir  out  18  instruction at queue head, to decoder ir input
ir_pc  out  PC_W  address of ir
ir_valid  out  1  queue non-empty
ir_ready  in  1  consumer takes ir this cycle when ir_valid=1
redirect_valid  in  1  execute requests a PC change
redirect_pc  in  PC_W  new fetch address

Behaviour:
- Interface: one clock; reset is asynchronous and active-low (rst_n).
- Reset state:
  - fetch_pc=RESET_PC; queue empty.
  - imem_req=0, ir_valid=0, drop flag=0.
  - ir and ir_pc are don't-care while ir_valid=0; drive them 0 at reset.
- Memory handshake:
  - At most one outstanding request.
  - imem_req asserts when (queue occupancy + outstanding) < QDEPTH and no redirect is present this cycle.
  - Once asserted, imem_req and imem_addr stay stable until the imem_ack cycle. A redirect does not withdraw a pending request.
  - imem_req may be reasserted in the cycle after ack, or in the same cycle if space allows (back-to-back fetch).
  - imem_ack while imem_req=0 is ignored.
- PC update:
  - On an accepted ack (not dropped, no redirect): fetch_pc <= fetch_pc+1, modulo 2^PC_W; 2^PC_W-1 wraps to 0.
  - Queue entry stores {imem_rdata, imem_addr}.
- Latency:
  - Ack in cycle N with an empty queue gives ir_valid=1 in cycle N+1. There is no combinational bypass from imem_rdata to ir.
  - With ir_ready held high and single-cycle ack, sustained throughput is 1 instruction/cycle.
- Queue:
  - FIFO with head on ir/ir_pc and ir_valid = !empty.
  - Pop when ir_valid && ir_ready. Push and pop in the same cycle are allowed, including when full.
  - Push when full never occurs, because the request gating counts the outstanding slot. Reaching it is an assertion failure.
- Redirect (highest priority):
  - In the redirect cycle: queue is flushed, pop is ignored, any ack data in that cycle is discarded, fetch_pc <= redirect_pc.
  - If a request is outstanding and unacked at redirect: set drop flag. The next ack clears the flag and its data is discarded; fetch_pc is not incremented.
  - The first request to redirect_pc issues in the cycle after the redirect, or the cycle after the dropped ack.
  - ir_valid=0 in the cycle after redirect.
  - A redirect while the drop flag is set updates fetch_pc again and keeps the flag set.
- Reset mid-operation: state returns immediately to the reset state. A pending memory transaction is abandoned; the memory side must also be reset.

Optional Feature:
- Macro FETCH_PERF_EN.
- Defined:
  - Adds output perf_bubbles (16 bits): counts cycles with rst_n=1, ir_valid=0 and no redirect.
  - Saturates at 16'hFFFF; reset to 0.
  - Adds input perf_clr (1 bit), which synchronously zeroes the counter.
- Undefined: both ports and the counter are absent; all other behaviour is identical.

Decomposition:
- Package fetch_pkg: INSTR_W=18; typedef fetch_entry_t {instr[17:0], pc}, parameterised via PC_W in the module.
- Natural sub-module: fetch_queue.
  - Synchronous FIFO with push/pop/flush, full/empty and occupancy count.
  - Generic over width and QDEPTH; pointers wrap modulo QDEPTH, with an explicit count to distinguish full from empty.

Test Plan:
- Reset release, ack tied high, ir_ready=1 → imem_addr 0,1,2,... on consecutive cycles; ir_valid first high 2 cycles after rst_n rises; ir_pc tracks 0,1,2.
- ir_ready=0, ack always high → exactly 2 words fetched (addr 0,1), imem_req drops. ir_ready=1 for one cycle → one pop, one new request at addr 2.
- Ack delayed 3 cycles with redirect_pc=0x0100 asserted at cycle 1 → pending addr stays stable, data of that ack is dropped, next imem_addr=0x0100, and the first ir_valid has ir_pc=0x0100.
- Redirect coinciding with ack and pop, queue full → queue empty next cycle, no pop counted, ack data discarded, fetch_pc=redirect_pc.
- PC_W=4, RESET_PC=14, continuous fetch → addresses 14,15,0,1.
- FETCH_PERF_EN: 5 idle cycles (ir_ready=1, ack withheld) → perf_bubbles increments by 5; perf_clr → 0; counter does not count during a redirect cycle.
